// File: rtl/addr_sweep_ctrl_pkg.sv
// Shared definitions for the address sweep controller: state encoding,
// default counter width and requester indices.
package addr_sweep_ctrl_pkg;

  localparam int CNT_WIDTH_DEF = 7;

  localparam int REQ_RD = 0;
  localparam int REQ_WR = 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

endpackage

// File: rtl/addr_sweep_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to
// the requester named by the priority pointer. Purely combinational.
module rr_arbiter2
  import addr_sweep_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o[REQ_RD] = 1'b1;
      2'b10:   grant_o[REQ_WR] = 1'b1;
      2'b11: begin
        if (ptr_i) grant_o[REQ_WR] = 1'b1;
        else       grant_o[REQ_RD] = 1'b1;
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/addr_sweep_ctrl.sv
// Sequences a shared address counter for two requesters: grants one at a
// time, enables the counter for exactly len beats, then clears it.
module addr_sweep_ctrl
  import addr_sweep_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_i,
  input  logic [CNT_WIDTH-1:0] len0_i,
  input  logic [CNT_WIDTH-1:0] len1_i,
  input  logic                 stall_i,
  output logic [1:0]           grant_o,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic [1:0]           done_o,
  output logic                 busy_o
);

  localparam logic [CNT_WIDTH-1:0] BEAT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic                 ptr_q, ptr_d;

  logic [1:0]           arb_grant;
  logic [CNT_WIDTH-1:0] len_sel;

  rr_arbiter2 u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant)
  );

  assign len_sel = arb_grant[REQ_WR] ? len1_i : len0_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      len_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ptr_d     = ptr_q;
    cnt_en_o  = 1'b0;
    cnt_clr_o = 1'b0;
    done_o    = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d = arb_grant;
          len_d   = len_sel;
          beat_d  = '0;
          state_d = (len_sel != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        cnt_en_o = !stall_i;
        if (cnt_en_o) begin
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == len_q - BEAT_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_clr_o = 1'b1;
        done_o    = grant_q;
        grant_d   = 2'b00;
        // Favour the other requester next time a tie occurs.
        ptr_d     = ~grant_q[REQ_WR];
        state_d   = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_addr_sweep_ctrl.sv
// Directed bench for addr_sweep_ctrl: a table of sweeps plus a hand-written
// asynchronous-reset-mid-sweep sequence, against a model external counter.
module tb_addr_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_r = 2'b00;
  logic [6:0] len0_r = '0;
  logic [6:0] len1_r = '0;
  logic       stall_r = 1'b0;
  logic [1:0] grant_o;
  logic       cnt_en_o;
  logic       cnt_clr_o;
  logic [1:0] done_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_model;

  addr_sweep_ctrl #(.CNT_WIDTH(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_r),
    .len0_i    (len0_r),
    .len1_i    (len1_r),
    .stall_i   (stall_r),
    .grant_o   (grant_o),
    .cnt_en_o  (cnt_en_o),
    .cnt_clr_o (cnt_clr_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  // External address counter driven by the controller.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_model <= 0;
    else if (cnt_clr_o) cnt_model <= 0;
    else if (cnt_en_o)  cnt_model <= cnt_model + 1;
  end

  typedef struct {
    logic [1:0] req;
    logic [6:0] len0;
    logic [6:0] len1;
    int         stall_at;
    int         drop_at;
    logic [1:0] exp_grant;
    int         exp_beats;
    int         exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one sweep starting before the next rising edge, then checks the
  // cycle after the done pulse is back in IDLE with the counter cleared.
  task automatic run_sweep(input int id, input vec_t v);
    int         beats = 0;
    int         done_cyc = 0;
    int         cnt_at_done = -1;
    logic [1:0] done_bits = 2'b00;
    logic [1:0] g1 = 2'b00;
    int         grant_bad = 0;
    int         busy_bad = 0;
    int         clr_bad = 0;
    int         clr_ok = 0;
    string      tag;
    tag = $sformatf("vec%0d", id);
    req_r   = v.req;
    len0_r  = v.len0;
    len1_r  = v.len1;
    stall_r = 1'b0;
    for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
      @(posedge clk); #1;
      stall_r = (c == v.stall_at);
      if (c == v.drop_at) begin
        req_r  = 2'b00;
        len0_r = 7'd3;
        len1_r = 7'd3;
      end
      @(negedge clk);
      if (c == 1) g1 = grant_o;
      if (grant_o != v.exp_grant) grant_bad++;
      if (!busy_o) busy_bad++;
      if (cnt_en_o) beats++;
      if (done_o != 2'b00) begin
        done_cyc    = c;
        done_bits   = done_o;
        clr_ok      = int'(cnt_clr_o && !cnt_en_o);
        cnt_at_done = cnt_model;
        req_r       = req_r & ~done_o;
      end else if (cnt_clr_o) begin
        clr_bad++;
      end
    end
    stall_r = 1'b0;
    chk({tag, "_grant_c1"}, int'(g1), int'(v.exp_grant));
    chk({tag, "_grant_held"}, grant_bad, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_beats"}, beats, v.exp_beats);
    chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
    chk({tag, "_done_bits"}, int'(done_bits), int'(v.exp_grant));
    chk({tag, "_clr_in_done"}, clr_ok, 1);
    chk({tag, "_stray_clr"}, clr_bad, 0);
    chk({tag, "_cnt_before_clr"}, cnt_at_done, v.exp_beats);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(busy_o), 0);
    chk({tag, "_idle_grant"}, int'(grant_o), 0);
    chk({tag, "_idle_done"}, int'(done_o), 0);
    chk({tag, "_cnt_cleared"}, cnt_model, 0);
    $display("[TB] sweep %0d req=%b len0=%0d len1=%0d grant=%b beats=%0d done@%0d cnt=%0d",
             id, v.req, v.len0, v.len1, g1, beats, done_cyc, cnt_at_done);
  endtask

  initial begin
    int beats;
    int done_seen;
    vec_t rv;

    //         req    len0    len1  stall drop grant  beats done
    vecs[0] = '{2'b01, 7'd4,   7'd9, 0,    0,   2'b01, 4,    5};
    vecs[1] = '{2'b10, 7'd0,   7'd3, 2,    0,   2'b10, 3,    5};
    vecs[2] = '{2'b11, 7'd2,   7'd5, 0,    0,   2'b01, 2,    3};
    vecs[3] = '{2'b10, 7'd2,   7'd5, 0,    0,   2'b10, 5,    6};
    vecs[4] = '{2'b11, 7'd2,   7'd5, 0,    0,   2'b01, 2,    3};
    vecs[5] = '{2'b01, 7'd0,   7'd5, 0,    0,   2'b01, 0,    1};
    vecs[6] = '{2'b01, 7'd127, 7'd5, 0,    5,   2'b01, 127,  128};
    vecs[7] = '{2'b01, 7'd1,   7'd5, 1,    0,   2'b01, 1,    3};

    repeat (3) @(negedge clk);
    chk("rst_grant", int'(grant_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_en", int'(cnt_en_o), 0);
    chk("rst_clr", int'(cnt_clr_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_sweep(i, vecs[i]);

    // Asynchronous reset after three beats of a 10-beat sweep.
    req_r  = 2'b01;
    len0_r = 7'd10;
    beats  = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (cnt_en_o) beats++;
    end
    chk("rstrun_beats_before", beats, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("rstrun_grant", int'(grant_o), 0);
    chk("rstrun_en", int'(cnt_en_o), 0);
    chk("rstrun_busy", int'(busy_o), 0);
    chk("rstrun_cnt", cnt_model, 0);
    done_seen = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (done_o != 2'b00) done_seen++;
    end
    chk("rstrun_no_done", done_seen, 0);
    $display("[TB] reset mid-sweep after %0d beats, grant=%b busy=%b", beats, grant_o, busy_o);
    rst_n = 1'b1;
    rv = '{2'b01, 7'd10, 7'd0, 0, 0, 2'b01, 10, 11};
    run_sweep(8, rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
